lab2_proc_xm_skid_buffer: RTL and testbench

- Decoupling buffer between the X-stage ALU and the M stage of the 5-stage pipelined processor.
- Captures the ALU result, its three condition flags, and the writeback tag each cycle.
- Forwards them to M through a val/rdy handshake with two entries of storage, so M-stage stalls do not combinationally reach X.
- Resolves branch-taken from the captured flags on the buffer head.

---
 rtl/lab2_proc_xm_skid_buffer.sv | 174 +++++++++++++++++
 tb/tb_lab2_proc_xm_skid_buffer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lab2_proc_xm_skid_buffer.sv
//------------------------------------------------------------------------------
// lab2_proc_xm_skid_buffer : two-entry X->M val/rdy skid buffer, resolves branches on head.
// Optional D-stage bypass outputs: define LAB2_PROC_XM_SKID_BYPASS_EN.   Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lab2_proc_xm_skid_buffer #(
  parameter int p_nbits = 32,
  parameter int p_naddr = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [p_nbits-1:0] in_result,
  input  logic               in_ops_eq,
  input  logic               in_op0_zero,
  input  logic               in_op0_neg,
  input  logic [2:0]         in_br_type,
  input  logic [p_naddr-1:0] in_rf_waddr,
  input  logic               in_rf_wen,
  input  logic               squash,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] out_result,
  output logic [p_naddr-1:0] out_rf_waddr,
  output logic               out_rf_wen,
  output logic               out_br_taken
`ifdef LAB2_PROC_XM_SKID_BYPASS_EN
  ,
  output logic               byp_val,
  output logic [p_naddr-1:0] byp_waddr,
  output logic [p_nbits-1:0] byp_data
`endif
);

  localparam logic [2:0] c_br_beq  = 3'd1;
  localparam logic [2:0] c_br_bne  = 3'd2;
  localparam logic [2:0] c_br_blez = 3'd3;
  localparam logic [2:0] c_br_bgtz = 3'd4;
  localparam logic [2:0] c_br_bltz = 3'd5;
  localparam logic [2:0] c_br_bgez = 3'd6;

  typedef struct packed {
    logic [p_nbits-1:0] result;
    logic               eq;
    logic               zero;
    logic               neg;
    logic [2:0]         br_type;
    logic [p_naddr-1:0] waddr;
    logic               wen;
  } entry_t;

  logic [1:0] r_count;
  logic [1:0] w_count_nxt;
  entry_t     r_head;
  entry_t     r_tail;
  entry_t     w_in_entry;
  entry_t     w_head_nxt;
  logic       w_head_we;
  logic       w_tail_we;
  logic       w_enq;
  logic       w_deq;
  logic       w_taken;

  assign w_in_entry = '{result:  in_result,
                        eq:      in_ops_eq,
                        zero:    in_op0_zero,
                        neg:     in_op0_neg,
                        br_type: in_br_type,
                        waddr:   in_rf_waddr,
                        wen:     in_rf_wen};

  // Ready is a pure function of state so M-stage stalls never reach X combinationally.
  assign in_rdy  = (r_count != 2'd2);
  assign out_val = (r_count != 2'd0);
  assign w_enq   = in_val & in_rdy & ~squash;
  assign w_deq   = out_val & out_rdy;

  always_comb begin
    w_count_nxt = r_count;
    w_head_nxt  = w_in_entry;
    w_head_we   = 1'b0;
    w_tail_we   = 1'b0;
    if (squash) begin
      // Any same-cycle dequeue has already been taken by M; everything else is dropped.
      w_count_nxt = 2'd0;
    end else begin
      case (r_count)
        2'd0: begin
          if (w_enq) begin
            w_head_we   = 1'b1;
            w_count_nxt = 2'd1;
          end
        end
        2'd1: begin
          if (w_enq && w_deq) begin
            w_head_we = 1'b1;
          end else if (w_enq) begin
            w_tail_we   = 1'b1;
            w_count_nxt = 2'd2;
          end else if (w_deq) begin
            w_count_nxt = 2'd0;
          end
        end
        2'd2: begin
          if (w_deq) begin
            w_head_we   = 1'b1;
            w_head_nxt  = r_tail;
            w_count_nxt = 2'd1;
          end
        end
        default: w_count_nxt = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_head_we) r_head <= w_head_nxt;
      if (w_tail_we) r_tail <= w_in_entry;
    end
  end

  always_comb begin
    w_taken = 1'b0;
    case (r_head.br_type)
      c_br_beq:  w_taken = r_head.eq;
      c_br_bne:  w_taken = ~r_head.eq;
      c_br_blez: w_taken = r_head.neg | r_head.zero;
      c_br_bgtz: w_taken = ~r_head.neg & ~r_head.zero;
      c_br_bltz: w_taken = r_head.neg;
      c_br_bgez: w_taken = ~r_head.neg;
      default:   w_taken = 1'b0;
    endcase
  end

  assign out_result   = r_head.result;
  assign out_rf_waddr = r_head.waddr;
  assign out_rf_wen   = out_val & r_head.wen;
  assign out_br_taken = out_val & w_taken;

`ifdef LAB2_PROC_XM_SKID_BYPASS_EN
  logic w_tail_byp;
  logic w_head_byp;

  // Newest writer wins: the tail is younger than the head when both are valid.
  assign w_tail_byp = (r_count == 2'd2) & r_tail.wen & (r_tail.waddr != '0);
  assign w_head_byp = out_val & r_head.wen & (r_head.waddr != '0);

  always_comb begin
    byp_val   = 1'b0;
    byp_waddr = '0;
    byp_data  = '0;
    if (w_tail_byp) begin
      byp_val   = 1'b1;
      byp_waddr = r_tail.waddr;
      byp_data  = r_tail.result;
    end else if (w_head_byp) begin
      byp_val   = 1'b1;
      byp_waddr = r_head.waddr;
      byp_data  = r_head.result;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_lab2_proc_xm_skid_buffer.sv
//------------------------------------------------------------------------------
// tb_lab2_proc_xm_skid_buffer : directed self-checking bench for the X->M skid buffer.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_lab2_proc_xm_skid_buffer;

  logic        clk;
  logic        reset;
  logic        in_val;
  logic        in_rdy;
  logic [31:0] in_result;
  logic        in_ops_eq;
  logic        in_op0_zero;
  logic        in_op0_neg;
  logic [2:0]  in_br_type;
  logic [4:0]  in_rf_waddr;
  logic        in_rf_wen;
  logic        squash;
  logic        out_val;
  logic        out_rdy;
  logic [31:0] out_result;
  logic [4:0]  out_rf_waddr;
  logic        out_rf_wen;
  logic        out_br_taken;
`ifdef LAB2_PROC_XM_SKID_BYPASS_EN
  logic        byp_val;
  logic [4:0]  byp_waddr;
  logic [31:0] byp_data;
`endif

  int tests_run;
  int tests_failed;

  lab2_proc_xm_skid_buffer #(.p_nbits(32), .p_naddr(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_val       (in_val),
    .in_rdy       (in_rdy),
    .in_result    (in_result),
    .in_ops_eq    (in_ops_eq),
    .in_op0_zero  (in_op0_zero),
    .in_op0_neg   (in_op0_neg),
    .in_br_type   (in_br_type),
    .in_rf_waddr  (in_rf_waddr),
    .in_rf_wen    (in_rf_wen),
    .squash       (squash),
    .out_val      (out_val),
    .out_rdy      (out_rdy),
    .out_result   (out_result),
    .out_rf_waddr (out_rf_waddr),
    .out_rf_wen   (out_rf_wen),
    .out_br_taken (out_br_taken)
`ifdef LAB2_PROC_XM_SKID_BYPASS_EN
    ,
    .byp_val      (byp_val),
    .byp_waddr    (byp_waddr),
    .byp_data     (byp_data)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic val, input logic [31:0] res, input logic eq,
                       input logic zero, input logic neg, input logic [2:0] br,
                       input logic [4:0] waddr, input logic wen);
    in_val      = val;
    in_result   = res;
    in_ops_eq   = eq;
    in_op0_zero = zero;
    in_op0_neg  = neg;
    in_br_type  = br;
    in_rf_waddr = waddr;
    in_rf_wen   = wen;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset   = 1'b0;
    squash  = 1'b0;
    out_rdy = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 1'b0);

    // Reset then idle
    step();
    check("rst_out_val", 32'(out_val), 32'd0);
    step();
    reset = 1'b1;
    step();
    check("idle_out_val", 32'(out_val), 32'd0);
    check("idle_in_rdy", 32'(in_rdy), 32'd1);
    check("idle_wen", 32'(out_rf_wen), 32'd0);
    check("idle_br_taken", 32'(out_br_taken), 32'd0);
    check("idle_result", out_result, 32'h0);

    // Streaming
    out_rdy = 1'b1;
    drive(1'b1, 32'h00000005, 1'b0, 1'b0, 1'b0, 3'd0, 5'd3, 1'b1);
    step();
    check("stream_a_val", 32'(out_val), 32'd1);
    check("stream_a_result", out_result, 32'h00000005);
    check("stream_a_waddr", 32'(out_rf_waddr), 32'd3);
    check("stream_a_wen", 32'(out_rf_wen), 32'd1);
    check("stream_a_in_rdy", 32'(in_rdy), 32'd1);
`ifdef LAB2_PROC_XM_SKID_BYPASS_EN
    check("stream_a_byp_val", 32'(byp_val), 32'd1);
    check("stream_a_byp_data", byp_data, 32'h00000005);
`endif
    drive(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 3'd0, 5'd4, 1'b0);
    step();
    check("stream_b_result", out_result, 32'hFFFFFFFF);
    check("stream_b_wen", 32'(out_rf_wen), 32'd0);
    check("stream_b_in_rdy", 32'(in_rdy), 32'd1);
    in_val = 1'b0;
    step();
    check("stream_drain_val", 32'(out_val), 32'd0);

    // Backpressure
    out_rdy = 1'b0;
    drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 3'd0, 5'd1, 1'b1);
    step();
    check("bp_a_result", out_result, 32'h11);
    check("bp_a_in_rdy", 32'(in_rdy), 32'd1);
    drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 3'd0, 5'd2, 1'b1);
    step();
    check("bp_full_in_rdy", 32'(in_rdy), 32'd0);
    check("bp_full_head", out_result, 32'h11);
    drive(1'b1, 32'h33, 1'b0, 1'b0, 1'b0, 3'd0, 5'd3, 1'b1);
    step();
    check("bp_hold_in_rdy", 32'(in_rdy), 32'd0);
    check("bp_hold_head", out_result, 32'h11);
    out_rdy = 1'b1;
    step();
    check("bp_b_result", out_result, 32'h22);
    check("bp_b_in_rdy", 32'(in_rdy), 32'd1);
    step();
    check("bp_c_result", out_result, 32'h33);
    check("bp_c_val", 32'(out_val), 32'd1);
    in_val = 1'b0;
    step();
    check("bp_drain_val", 32'(out_val), 32'd0);

    // Branch resolution on head
    drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 3'd2, 5'd0, 1'b0);
    step();
    check("br_bne_ne", 32'(out_br_taken), 32'd1);
    drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 3'd6, 5'd0, 1'b0);
    step();
    check("br_bgez_neg", 32'(out_br_taken), 32'd0);
    drive(1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 3'd3, 5'd0, 1'b0);
    step();
    check("br_blez_zero", 32'(out_br_taken), 32'd1);
    drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 3'd7, 5'd0, 1'b0);
    step();
    check("br_reserved", 32'(out_br_taken), 32'd0);
    drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 3'd4, 5'd0, 1'b0);
    step();
    check("br_bgtz_pos", 32'(out_br_taken), 32'd1);
    in_val = 1'b0;
    step();
    check("br_idle_taken", 32'(out_br_taken), 32'd0);

    // Squash with a full buffer and a same-cycle dequeue
    out_rdy = 1'b0;
    drive(1'b1, 32'hA1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd5, 1'b1);
    step();
    drive(1'b1, 32'hA2, 1'b0, 1'b0, 1'b0, 3'd0, 5'd6, 1'b1);
    step();
    check("sq_full_in_rdy", 32'(in_rdy), 32'd0);
    out_rdy = 1'b1;
    squash  = 1'b1;
    drive(1'b1, 32'hA3, 1'b0, 1'b0, 1'b0, 3'd0, 5'd7, 1'b1);
    check("sq_head_deq", out_result, 32'hA1);
    step();
    check("sq_out_val", 32'(out_val), 32'd0);
    check("sq_in_rdy", 32'(in_rdy), 32'd1);
    squash = 1'b0;
    in_val = 1'b0;
    step();
    check("sq_no_capture", 32'(out_val), 32'd0);

    // Asynchronous reset between edges
    out_rdy = 1'b0;
    drive(1'b1, 32'hB1, 1'b0, 1'b0, 1'b0, 3'd0, 5'd1, 1'b1);
    step();
    drive(1'b1, 32'hB2, 1'b0, 1'b0, 1'b0, 3'd0, 5'd2, 1'b1);
    step();
    in_val = 1'b0;
    check("ar_full_val", 32'(out_val), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("ar_async_val", 32'(out_val), 32'd0);
    check("ar_async_in_rdy", 32'(in_rdy), 32'd1);
    step();
    reset = 1'b1;
    step();
    check("ar_after_val", 32'(out_val), 32'd0);
    check("ar_after_wen", 32'(out_rf_wen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
